uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial-to-byte UART receiver.
- Sits directly upstream of the memory-access command controller. It drives the RX_data/byte_done pair that the controller decodes into write/read frames.
- Format: 8N1, LSB first, 16x oversampling with 3-sample majority vote.
- Flags false starts and framing errors, so only clean bytes reach the controller.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- OVERSAMPLE, 16, ticks per bit; fixed at 16 (majority taps assume it).
- TICK_DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer divide, 54 at defaults), clocks per oversample tick.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial line, idle high, asynchronous to clk.
- RX_data  out  8  last correctly received byte.
- byte_done  out  1  one-cycle pulse: RX_data holds a new byte.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release): all outputs reset as follows.
  - RX_data=0, byte_done=0, frame_err=0, busy=0.
  - Synchroniser flops = 1, tick counter = 0, state = IDLE.
- Input: rx passes through a 2-flop synchroniser; rx_s is the second flop. All logic uses only rx_s.
- Tick generator: counts 0..TICK_DIV-1 and emits a 1-cycle tick at TICK_DIV-1.
  - Restarts from 0 on the cycle IDLE detects the start edge, so bit timing is edge-aligned.
- Counters: sub-bit counter s_cnt 0..15 (advances on tick); bit counter b_cnt 0..7.
- States:
  - IDLE:
    - rx_s==0 -> START; s_cnt=0, tick gen cleared.
  - START:
    - Samples at s_cnt 7,8,9; majority evaluated on tick with s_cnt==9.
    - Majority 1 = false start -> IDLE; no pulse of any kind.
    - Majority 0 -> continue; at s_cnt==15 tick -> DATA with b_cnt=0.
  - DATA:
    - Same 7/8/9 majority per bit, shifted into the shift register LSB first.
    - At s_cnt==15 tick: if b_cnt==7 -> STOP, else b_cnt+1.
  - STOP:
    - Majority of ticks 7/8/9, evaluated at s_cnt==9.
    - Majority 1: RX_data <= shift register and byte_done=1 for exactly one cycle, same cycle; then -> IDLE immediately, no wait for the rest of the stop bit.
    - Majority 0: frame_err=1 for one cycle, RX_data unchanged, no byte_done; -> BREAK.
  - BREAK:
    - Waits until rx_s==1 for 16 consecutive ticks, then -> IDLE. Covers a held-low line or break condition.
- Output stability: RX_data changes only on the byte_done cycle and is stable until the next byte_done. The downstream controller compares RX_data in the same cycle byte_done is high.
- Latency: byte_done rises (9*16+10)*TICK_DIV clocks after the start edge, plus 2-3 clocks for the synchroniser.
  - Defaults: 154*54 = 8316 clocks, +2..3.
- Back-to-back frames: leaving STOP at mid-stop-bit leaves ~6 ticks of slack, so a start edge arriving immediately after the stop bit is caught.
- Glitches: a low pulse shorter than ~7 ticks is rejected as a false start. A single-tick glitch inside a data bit is outvoted by the majority.
- Reset mid-frame: asserting rst in any state aborts the frame with no pulse. After release the receiver waits in IDLE for the next falling edge; a line already low at release is treated as a start edge.
- Exclusivity: byte_done and frame_err are never high in the same cycle.

Test Plan:
- Clean frame: rst pulse, send 0x0F at 115200 baud -> one byte_done pulse with RX_data=0x0F at edge+8316(+2..3) clks; frame_err stays 0; busy high in between.
- Back-to-back: 0xFF,0x34,0x12 with no idle gap -> three byte_done pulses; RX_data reads 0xFF, 0x34, 0x12 in that order; pulses ~8640 clks apart.
- False start: 4-tick (216-clk) low pulse on idle line -> busy rises then returns to 0; no byte_done; no frame_err. A following 0xA5 frame is received correctly.
- Framing error: send 0x55 with stop bit low, line high after 2 bit times -> frame_err pulse, no byte_done, RX_data keeps previous value. Next 0x3C is received as 0x3C.
- Majority vote: send 0x00 with a 1-tick high glitch at tick 8 of bit 3 -> RX_data=0x00. Glitch spanning ticks 7-9 -> RX_data=0x08.
- Reset mid-frame: assert rst during bit 4 of 0x96 -> outputs go to 0 asynchronously; no pulse. A following 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, 16x oversampling with a 3-sample
// majority vote at mid-bit. Rejects false starts and reports framing errors,
// so only clean bytes are presented on RX_data/byte_done.
module uart_rx #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] RX_data,
    output logic       byte_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [3:0]  S_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          start_det;
    logic [3:0]    s_cnt;
    logic [2:0]    b_cnt;
    logic [1:0]    samp;
    logic          maj;
    logic [7:0]    shreg;

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign start_det = (state == IDLE) && !rx_s;
    // Third vote is the live sample taken on the s_cnt==9 tick itself.
    assign maj       = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // Oversample tick generator, realigned to the detected start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_det || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Receive FSM with registered pulses, data register and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            s_cnt     <= '0;
            b_cnt     <= '0;
            samp      <= '0;
            shreg     <= '0;
            RX_data   <= '0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            frame_err <= 1'b0;

            if (tick && s_cnt == 4'd7) samp[0] <= rx_s;
            if (tick && s_cnt == 4'd8) samp[1] <= rx_s;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_cnt <= '0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd9 && maj) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (s_cnt == S_LAST) begin
                            state <= DATA;
                            b_cnt <= '0;
                        end
                    end
                end

                DATA: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd9) shreg <= {maj, shreg[7:1]};
                        if (s_cnt == S_LAST) begin
                            if (b_cnt == 3'd7) state <= STOP;
                            else               b_cnt <= b_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (tick) begin
                        s_cnt <= s_cnt + 4'd1;
                        if (s_cnt == 4'd9) begin
                            if (maj) begin
                                RX_data   <= shreg;
                                byte_done <= 1'b1;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                                s_cnt     <= '0;
                            end
                        end
                    end
                end

                BREAK: begin
                    // s_cnt counts consecutive high ticks while the line recovers.
                    if (tick) begin
                        if (!rx_s) begin
                            s_cnt <= '0;
                        end else if (s_cnt == S_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
